// File: rtl/output_capture_fifo_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : output_capture_fifo_pkg
//  Purpose  : Shared constants, types and helpers for the output capture FIFO.
//             Provides the parameter defaults. It also provides the write-side
//             classification used by the top level to tell an accepted capture
//             from a dropped one.
//  Ports    : (package - none)
//  Revision : 1.0 - initial release
// ============================================================================
package output_capture_fifo_pkg;

    localparam int c_DEFAULT_DATA_W            = 4;
    localparam int c_DEFAULT_DEPTH             = 8;
    localparam int c_DEFAULT_CAPTURE_ON_CHANGE = 1;

    // Outcome of a capture request in a given cycle.
    typedef enum logic [1:0] {
        WR_NONE   = 2'd0,   // nothing to capture
        WR_ACCEPT = 2'd1,   // value written into the FIFO
        WR_DROP   = 2'd2    // FIFO full and not draining: value lost
    } wr_action_e;

    // A full FIFO still accepts a capture when the head is popped in the
    // same cycle, because the pop frees the slot the write lands in.
    function automatic wr_action_e classify_write(
        input logic push,
        input logic full,
        input logic pop
    );
        wr_action_e action;
        action = WR_NONE;
        if (push) begin
            if (!full || pop) begin
                action = WR_ACCEPT;
            end else begin
                action = WR_DROP;
            end
        end
        return action;
    endfunction

endpackage : output_capture_fifo_pkg
`default_nettype wire

// File: rtl/output_capture_fifo_sync_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : sync_fifo
//  Purpose  : Single-clock FIFO. It has a registered occupancy count and
//             wrapping pointers. The head is read combinationally from the
//             read pointer, so no fall-through occurs: a word written at an
//             edge becomes visible just after that edge.
//  Ports    : clk   - clock, rising edge
//             reset - asynchronous active-high; clears pointers and count
//             push  - write request (qualified internally against full/pop)
//             din   - write data
//             pop   - read request (ignored while empty)
//             dout  - head word (undefined content while empty)
//             full  - count == DEPTH
//             empty - count == 0
//             count - stored entries, 0..DEPTH
//  Revision : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 4,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push,
    input  logic [DATA_W-1:0]          din,
    input  logic                       pop,
    output logic [DATA_W-1:0]          dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_PTR_W-1:0] r_wr_ptr;
    logic [c_PTR_W-1:0] r_rd_ptr;
    logic [c_CNT_W-1:0] r_count;

    logic w_wr_en;
    logic w_rd_en;

    assign full  = (r_count == c_CNT_W'(DEPTH));
    assign empty = (r_count == '0);
    assign count = r_count;
    assign dout  = r_mem[r_rd_ptr];

    assign w_rd_en = pop && !empty;
    // A same-cycle pop vacates the slot, so a write to a full FIFO is legal then.
    assign w_wr_en = push && (!full || w_rd_en);

    // Storage carries no reset; validity is tracked entirely by the count.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_rd_en) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_wr_en && !w_rd_en) begin
                r_count <= r_count + c_CNT_W'(1);
            end else if (w_rd_en && !w_wr_en) begin
                r_count <= r_count - c_CNT_W'(1);
            end
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/output_capture_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : output_capture_fifo
//  Purpose  : Samples the CPU output bus every clock and records new values
//             into a FIFO. A consumer drains the FIFO over valid/ready. A
//             capture lost to a full FIFO raises a sticky overflow flag.
//  Ports    : clk          - clock, rising edge
//             reset        - asynchronous active-high; clears all state
//             in_data      - CPU output bus being monitored
//             out_data     - FIFO head, forced to 0 while out_valid = 0
//             out_valid    - head entry available
//             out_ready    - consumer takes the head this cycle
//             count        - entries stored, 0..DEPTH
//             overflow     - sticky drop indicator
//             clr_overflow - synchronous clear of overflow (a drop wins)
//  Revision : 1.0 - initial release
// ============================================================================
module output_capture_fifo
    import output_capture_fifo_pkg::*;
#(
    parameter int DATA_W            = c_DEFAULT_DATA_W,
    parameter int DEPTH             = c_DEFAULT_DEPTH,
    parameter int CAPTURE_ON_CHANGE = c_DEFAULT_CAPTURE_ON_CHANGE
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [DATA_W-1:0]          in_data,
    output logic [DATA_W-1:0]          out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    input  logic                       clr_overflow
);

    localparam int c_PTR_W = $clog2(DEPTH);
    localparam int c_CNT_W = c_PTR_W + 1;

    logic [DATA_W-1:0]  r_last;
    logic               r_primed;
    logic               r_overflow;

    logic               w_push;
    logic               w_pop;
    logic               w_full;
    logic               w_empty;
    logic [DATA_W-1:0]  w_dout;
    logic [c_CNT_W-1:0] w_count;
    wr_action_e         w_action;

    // ------------------------------------------------------------------
    // Capture decision
    // ------------------------------------------------------------------
    generate
        if (CAPTURE_ON_CHANGE != 0) begin : g_capture_on_change
            // Unprimed means the first sample after reset, which is always
            // recorded even when it matches the cleared last-sample register.
            assign w_push = !r_primed || (in_data != r_last);
        end else begin : g_capture_every_cycle
            assign w_push = 1'b1;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_last   <= '0;
            r_primed <= 1'b0;
        end else begin
            r_last   <= in_data;
            r_primed <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    assign w_pop = out_valid && out_ready;

    sync_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_sync_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (in_data),
        .pop   (w_pop),
        .dout  (w_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // ------------------------------------------------------------------
    // Overflow tracking
    // ------------------------------------------------------------------
    assign w_action = classify_write(w_push, w_full, w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_overflow <= 1'b0;
        end else if (w_action == WR_DROP) begin
            r_overflow <= 1'b1;
        end else if (clr_overflow) begin
            r_overflow <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign out_valid = !w_empty;
    // The memory is not reset, so mask whatever stale word the read
    // pointer addresses while the FIFO is empty.
    assign out_data  = out_valid ? w_dout : '0;
    assign count     = w_count;
    assign overflow  = r_overflow;

endmodule : output_capture_fifo
`default_nettype wire

// File: tb/tb_output_capture_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_output_capture_fifo
//  Purpose  : Self-checking bench for output_capture_fifo. It combines table
//             vectors and hand-written corner sequences with a randomized
//             run. All of these are checked against a queue-based reference
//             model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_output_capture_fifo;

    localparam int DATA_W = 4;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = $clog2(DEPTH) + 1;

    logic              clk = 1'b0;
    logic              reset = 1'b1;
    logic [DATA_W-1:0] in_data = '0;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [CNT_W-1:0]  count;
    logic              overflow;
    logic              clr_overflow = 1'b0;

    int tests_run = 0;
    int tests_failed = 0;

    output_capture_fifo #(
        .DATA_W            (DATA_W),
        .DEPTH             (DEPTH),
        .CAPTURE_ON_CHANGE (1)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_data      (in_data),
        .out_data     (out_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .count        (count),
        .overflow     (overflow),
        .clr_overflow (clr_overflow)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- reference model (queue of captured values) ----------
    logic [DATA_W-1:0] mq[$];
    bit                m_primed;
    logic [DATA_W-1:0] m_last;
    bit                m_ovf;

    function automatic void model_reset();
        mq.delete();
        m_primed = 0;
        m_last   = '0;
        m_ovf    = 0;
    endfunction

    // One clock edge: the consumer takes the head if there is one, then a
    // captured value joins the tail if room remains, otherwise it is lost.
    function automatic void model_step(input logic [DATA_W-1:0] d, input bit rdy, input bit clr);
        bit want;
        bit dropped;
        want    = !m_primed || (d != m_last);
        dropped = 0;
        if (rdy && mq.size() > 0) void'(mq.pop_front());
        if (want) begin
            if (mq.size() < DEPTH) mq.push_back(d);
            else dropped = 1;
        end
        if (dropped)  m_ovf = 1;
        else if (clr) m_ovf = 0;
        m_last   = d;
        m_primed = 1;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic compare_model(input string name);
        logic [DATA_W-1:0] hd;
        hd = (mq.size() > 0) ? mq[0] : '0;
        check({name, ".valid"},    32'(out_valid), 32'(mq.size() > 0));
        check({name, ".data"},     32'(out_data),  32'(hd));
        check({name, ".count"},    32'(count),     32'(mq.size()));
        check({name, ".overflow"}, 32'(overflow),  32'(m_ovf));
    endtask

    task automatic step(input string name, input logic [DATA_W-1:0] d, input bit rdy, input bit clr);
        in_data      = d;
        out_ready    = rdy;
        clr_overflow = clr;
        @(posedge clk);
        model_step(d, rdy, clr);
        #1;
        compare_model(name);
    endtask

    task automatic do_reset(input logic [DATA_W-1:0] d);
        reset        = 1'b1;
        in_data      = d;
        out_ready    = 1'b0;
        clr_overflow = 1'b0;
        @(posedge clk);
        #1;
        model_reset();
        compare_model("reset");
        reset = 1'b0;
    endtask

    // ---------------- table vectors ----------------------------------------
    typedef struct {
        logic [DATA_W-1:0] in_data;
        bit                ready;
        bit                clr;
        bit                exp_valid;
        logic [DATA_W-1:0] exp_data;
        logic [CNT_W-1:0]  exp_count;
        bit                exp_ovf;
    } vec_t;

    vec_t tbl[$];

    initial begin
        // Change-detect then drain, after a reset taken with in_data = 3.
        tbl.push_back('{4'd3, 1'b0, 1'b0, 1'b1, 4'd3, 4'd1, 1'b0});
        tbl.push_back('{4'd3, 1'b0, 1'b0, 1'b1, 4'd3, 4'd1, 1'b0});
        tbl.push_back('{4'd5, 1'b0, 1'b0, 1'b1, 4'd3, 4'd2, 1'b0});
        tbl.push_back('{4'd5, 1'b0, 1'b0, 1'b1, 4'd3, 4'd2, 1'b0});
        tbl.push_back('{4'd9, 1'b0, 1'b0, 1'b1, 4'd3, 4'd3, 1'b0});
        tbl.push_back('{4'd9, 1'b1, 1'b0, 1'b1, 4'd5, 4'd2, 1'b0});
        tbl.push_back('{4'd9, 1'b1, 1'b0, 1'b1, 4'd9, 4'd1, 1'b0});
        tbl.push_back('{4'd9, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0});
        tbl.push_back('{4'd9, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0});

        // 1. Zero captured right after reset, held constant.
        do_reset(4'd0);
        step("zero_first", 4'd0, 1'b0, 1'b0);
        check("zero_first.exp_count", 32'(count), 32'd1);
        step("zero_hold", 4'd0, 1'b0, 1'b0);
        step("zero_hold", 4'd0, 1'b0, 1'b0);
        check("zero_hold.exp_count", 32'(count), 32'd1);

        // 2. Table: change detection and drain.
        do_reset(4'd3);
        for (int i = 0; i < tbl.size(); i++) begin
            step($sformatf("tbl%0d", i), tbl[i].in_data, tbl[i].ready, tbl[i].clr);
            check($sformatf("tbl%0d.exp_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            check($sformatf("tbl%0d.exp_data", i),  32'(out_data),  32'(tbl[i].exp_data));
            check($sformatf("tbl%0d.exp_count", i), 32'(count),     32'(tbl[i].exp_count));
            check($sformatf("tbl%0d.exp_ovf", i),   32'(overflow),  32'(tbl[i].exp_ovf));
        end

        // 3. Fill with 9 distinct values: ninth dropped, overflow set.
        do_reset(4'd0);
        for (int i = 0; i < 9; i++) begin
            step("fill", 4'(i), 1'b0, 1'b0);
        end
        check("fill.count", 32'(count), 32'd8);
        check("fill.overflow", 32'(overflow), 32'd1);
        check("fill.head", 32'(out_data), 32'd0);
        step("clr_ovf", 4'd8, 1'b0, 1'b1);
        check("clr_ovf.overflow", 32'(overflow), 32'd0);

        // 4. Full FIFO with a new value and a same-cycle pop: accepted.
        step("full_pop_push", 4'd12, 1'b1, 1'b0);
        check("full_pop_push.overflow", 32'(overflow), 32'd0);
        check("full_pop_push.count", 32'(count), 32'd8);
        check("full_pop_push.head", 32'(out_data), 32'd1);
        for (int i = 0; i < 8; i++) begin
            step("full_drain", 4'd12, 1'b1, 1'b0);
        end
        check("full_drain.count", 32'(count), 32'd0);

        // 5. Streaming: each value visible one edge after it appears.
        do_reset(4'd0);
        for (int i = 1; i <= 20; i++) begin
            step("stream", 4'(i % 16), 1'b1, 1'b0);
            check("stream.data", 32'(out_data), 32'(i % 16));
            check("stream.count", 32'(count), 32'd1);
        end

        // 6. Asynchronous reset mid-drain with count = 5.
        do_reset(4'd0);
        for (int i = 1; i <= 6; i++) begin
            step("pre_rst_fill", 4'(i), 1'b0, 1'b0);
        end
        step("pre_rst_drain", 4'd6, 1'b1, 1'b0);
        check("pre_rst_drain.count", 32'(count), 32'd5);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        check("async_rst.valid", 32'(out_valid), 32'd0);
        check("async_rst.count", 32'(count), 32'd0);
        check("async_rst.overflow", 32'(overflow), 32'd0);
        check("async_rst.data", 32'(out_data), 32'd0);
        @(posedge clk);
        #1;
        in_data = 4'd6;
        reset   = 1'b0;
        step("post_rst", 4'd6, 1'b0, 1'b0);
        check("post_rst.count", 32'(count), 32'd1);
        check("post_rst.data", 32'(out_data), 32'd6);

        // Randomized run against the model, with varying drain pressure.
        do_reset(4'($urandom_range(0, 15)));
        for (int i = 0; i < 600; i++) begin
            int rdy_pct;
            rdy_pct = (i / 100) % 3 == 0 ? 15 : ((i / 100) % 3 == 1 ? 85 : 50);
            if ($urandom_range(0, 199) == 0) begin
                do_reset(4'($urandom_range(0, 15)));
            end
            step("rand",
                 4'($urandom_range(0, 3)),
                 ($urandom_range(0, 99) < rdy_pct),
                 ($urandom_range(0, 15) == 0));
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_output_capture_fifo
`default_nettype wire
